// File: rtl/button_conditioner.sv
// Pushbutton front end: synchronise, debounce, and classify presses as short or long.
// A short press toggles the downstream counter's run enable. A long press issues a
// one-cycle counter reset.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic db_level,
  output logic rise_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic cnt_reset,
  output logic run_en
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_t;

  logic              s1_q, s2_q;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              db_level_q, db_level_d;
  logic              db_prev_q;
  state_t            state_q;
  logic [HOLD_W-1:0] hold_q;
  logic              rise_q, short_q, long_q;
  logic              run_en_q;

  logic db_rise, db_fall;

  // Two-flop synchroniser on the polarity-normalised pin (1 = pressed)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_raw ^ BTN_ACTIVE_LOW;
      s2_q <= s1_q;
    end
  end

  // Debounce: accept a new level only after it holds for DEBOUNCE_CYCLES samples
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    if (s2_q == db_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_level_d = s2_q;
      db_cnt_d   = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
    end else begin
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
    end
  end

  // Edges against the previous debounced level, so strobes trail db_level by one cycle
  assign db_rise = db_level_q & ~db_prev_q;
  assign db_fall = ~db_level_q & db_prev_q;

  // Press classifier FSM with registered strobes and run-enable toggle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      db_prev_q <= 1'b0;
      rise_q    <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      run_en_q  <= 1'b0;
    end else begin
      db_prev_q <= db_level_q;
      rise_q    <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      run_en_q  <= run_en_q ^ short_q;
      case (state_q)
        ST_IDLE: begin
          if (db_rise) begin
            state_q <= ST_PRESSED;
            hold_q  <= '0;
            rise_q  <= 1'b1;
          end
        end
        ST_PRESSED: begin
          // A release on the threshold cycle still counts as a short press
          if (db_fall) begin
            state_q <= ST_IDLE;
            short_q <= 1'b1;
          end else if (db_level_q && (hold_q == HOLD_LAST)) begin
            state_q <= ST_LONG;
            long_q  <= 1'b1;
          end else if (hold_q != HOLD_MAX) begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        ST_LONG: begin
          if (db_fall) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign db_level    = db_level_q;
  assign rise_pulse  = rise_q;
  assign short_pulse = short_q;
  assign long_pulse  = long_q;
  assign cnt_reset   = long_q;
  assign run_en      = run_en_q;

endmodule
